// File: rtl/register_file_2r1w_if.sv
// Operand-store port bundle: one write port, one reserve port,
// two read ports with their registered results.
interface register_file_2r1w_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  load;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  reserve;
    logic [ADDR_WIDTH-1:0] reserve_addr;
    logic [ADDR_WIDTH-1:0] raddr_a;
    logic [ADDR_WIDTH-1:0] raddr_b;
    logic [DATA_WIDTH-1:0] data_out_a;
    logic [DATA_WIDTH-1:0] data_out_b;
    logic                  pending_a;
    logic                  pending_b;
    logic                  any_pending;

    modport master (
        output load, waddr, data_in,
        output reserve, reserve_addr,
        output raddr_a, raddr_b,
        input  data_out_a, data_out_b,
        input  pending_a, pending_b, any_pending
    );

    modport slave (
        input  load, waddr, data_in,
        input  reserve, reserve_addr,
        input  raddr_a, raddr_b,
        output data_out_a, data_out_b,
        output pending_a, pending_b, any_pending
    );
endinterface

// File: rtl/register_file_2r1w.sv
// Two-read/one-write register file with a per-entry pending
// scoreboard and same-edge write-to-read bypass.
module register_file_2r1w #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ZERO_REG   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    register_file_2r1w_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      pend;
    logic [DEPTH-1:0]      pend_next;

    logic                  wr_ok;
    logic                  rsv_ok;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [DATA_WIDTH-1:0] rd_data_b;
    logic                  rd_pend_a;
    logic                  rd_pend_b;

    // Entry 0 is inert when hardwired to zero.
    assign wr_ok  = bus.load &&
                    !(ZERO_REG != 0 && bus.waddr == '0);
    assign rsv_ok = bus.reserve &&
                    !(ZERO_REG != 0 && bus.reserve_addr == '0);

    // Post-update scoreboard: a same-edge reserve beats the write.
    always_comb begin
        pend_next = pend;
        if (wr_ok) begin
            pend_next[bus.waddr] = 1'b0;
        end
        if (rsv_ok) begin
            pend_next[bus.reserve_addr] = 1'b1;
        end
    end

    // Read-port selection: array, bypass, then zero-register override.
    always_comb begin
        rd_data_a = mem[bus.raddr_a];
        rd_pend_a = pend[bus.raddr_a];
        if (wr_ok && bus.waddr == bus.raddr_a) begin
            rd_data_a = bus.data_in;
            rd_pend_a = pend_next[bus.raddr_a];
        end
        if (ZERO_REG != 0 && bus.raddr_a == '0) begin
            rd_data_a = '0;
            rd_pend_a = 1'b0;
        end

        rd_data_b = mem[bus.raddr_b];
        rd_pend_b = pend[bus.raddr_b];
        if (wr_ok && bus.waddr == bus.raddr_b) begin
            rd_data_b = bus.data_in;
            rd_pend_b = pend_next[bus.raddr_b];
        end
        if (ZERO_REG != 0 && bus.raddr_b == '0) begin
            rd_data_b = '0;
            rd_pend_b = 1'b0;
        end
    end

    // Storage and scoreboard update; reset discards same-edge traffic.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend <= '0;
        end else begin
            if (wr_ok) begin
                mem[bus.waddr] <= bus.data_in;
            end
            pend <= pend_next;
        end
    end

    // Registered read results and scoreboard summary.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.data_out_a  <= '0;
            bus.data_out_b  <= '0;
            bus.pending_a   <= 1'b0;
            bus.pending_b   <= 1'b0;
            bus.any_pending <= 1'b0;
        end else begin
            bus.data_out_a  <= rd_data_a;
            bus.data_out_b  <= rd_data_b;
            bus.pending_a   <= rd_pend_a;
            bus.pending_b   <= rd_pend_b;
            bus.any_pending <= |pend_next;
        end
    end
endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w: a plain instance and a
// zero-register instance driven from one sequence.
module tb_register_file_2r1w;
    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    register_file_2r1w_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) rf ();
    register_file_2r1w_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) zf ();

    register_file_2r1w #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ZERO_REG(0)
    ) dut (
        .clock(clock), .reset(reset), .bus(rf)
    );

    register_file_2r1w #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ZERO_REG(1)
    ) dut_zero (
        .clock(clock), .reset(reset), .bus(zf)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rf.load = 1'b0; rf.reserve = 1'b0;
        zf.load = 1'b0; zf.reserve = 1'b0;
    endtask

    initial begin
        rf.load = 0; rf.waddr = 0; rf.data_in = 0;
        rf.reserve = 0; rf.reserve_addr = 0;
        rf.raddr_a = 0; rf.raddr_b = 0;
        zf.load = 0; zf.waddr = 0; zf.data_in = 0;
        zf.reserve = 0; zf.reserve_addr = 0;
        zf.raddr_a = 0; zf.raddr_b = 0;

        // reset, then read addresses 1 and 15
        reset = 1'b1;
        step();
        check("rst_out_a", rf.data_out_a, 8'h00);
        check("rst_any", rf.any_pending, 1'b0);
        reset = 1'b0;
        rf.raddr_a = 4'd1; rf.raddr_b = 4'd15;
        step();
        check("rd0_data_a", rf.data_out_a, 8'h00);
        check("rd0_data_b", rf.data_out_b, 8'h00);
        check("rd0_pend_a", rf.pending_a, 1'b0);
        check("rd0_pend_b", rf.pending_b, 1'b0);
        check("rd0_any", rf.any_pending, 1'b0);

        // two writes, then independent reads
        rf.load = 1; rf.waddr = 4'd1; rf.data_in = 8'h04;
        step();
        rf.waddr = 4'd2; rf.data_in = 8'h05;
        step();
        idle();
        rf.raddr_a = 4'd1; rf.raddr_b = 4'd2;
        step();
        check("wr_data_a", rf.data_out_a, 8'h04);
        check("wr_data_b", rf.data_out_b, 8'h05);

        // bypass on both ports
        rf.load = 1; rf.waddr = 4'd3; rf.data_in = 8'hA5;
        rf.raddr_a = 4'd3; rf.raddr_b = 4'd3;
        step();
        check("byp_data_a", rf.data_out_a, 8'hA5);
        check("byp_data_b", rf.data_out_b, 8'hA5);
        check("byp_pend_a", rf.pending_a, 1'b0);
        idle();

        // top address and port independence
        rf.load = 1; rf.waddr = 4'd15; rf.data_in = 8'hF0;
        step();
        idle();
        rf.raddr_a = 4'd2; rf.raddr_b = 4'd15;
        step();
        check("top_data_a", rf.data_out_a, 8'h05);
        check("top_data_b", rf.data_out_b, 8'hF0);

        // scoreboard: reserve, write, reserve+write
        rf.reserve = 1; rf.reserve_addr = 4'd7;
        step();
        idle();
        rf.raddr_a = 4'd7;
        step();
        check("rsv_pend_a", rf.pending_a, 1'b1);
        check("rsv_any", rf.any_pending, 1'b1);
        check("rsv_pend_b", rf.pending_b, 1'b0);
        rf.load = 1; rf.waddr = 4'd7; rf.data_in = 8'h3C;
        step();
        idle();
        step();
        check("clr_pend_a", rf.pending_a, 1'b0);
        check("clr_data_a", rf.data_out_a, 8'h3C);
        check("clr_any", rf.any_pending, 1'b0);
        rf.load = 1; rf.waddr = 4'd7; rf.data_in = 8'h5A;
        rf.reserve = 1; rf.reserve_addr = 4'd7;
        step();
        check("both_pend_a", rf.pending_a, 1'b1);
        check("both_data_a", rf.data_out_a, 8'h5A);
        check("both_any", rf.any_pending, 1'b1);
        idle();
        step();
        check("both_hold_pend", rf.pending_a, 1'b1);

        // zero register: writes and reserves to 0 are inert
        zf.load = 1; zf.waddr = 4'd0; zf.data_in = 8'hFF;
        zf.reserve = 1; zf.reserve_addr = 4'd0;
        zf.raddr_a = 4'd0; zf.raddr_b = 4'd0;
        step();
        check("z_byp_data_a", zf.data_out_a, 8'h00);
        check("z_byp_pend_a", zf.pending_a, 1'b0);
        check("z_byp_any", zf.any_pending, 1'b0);
        idle();
        step();
        check("z_data_a", zf.data_out_a, 8'h00);
        check("z_data_b", zf.data_out_b, 8'h00);
        check("z_pend_b", zf.pending_b, 1'b0);
        check("z_any", zf.any_pending, 1'b0);
        zf.load = 1; zf.waddr = 4'd5; zf.data_in = 8'h77;
        step();
        idle();
        zf.raddr_b = 4'd5;
        step();
        check("z_nz_data_b", zf.data_out_b, 8'h77);

        // reset beats a same-edge write
        rf.load = 1; rf.waddr = 4'd4; rf.data_in = 8'h11;
        step();
        rf.data_in = 8'h22;
        rf.raddr_a = 4'd4;
        reset = 1'b1;
        step();
        check("rp_out_a", rf.data_out_a, 8'h00);
        check("rp_any", rf.any_pending, 1'b0);
        reset = 1'b0;
        idle();
        rf.raddr_b = 4'd7;
        step();
        check("rp_data_a", rf.data_out_a, 8'h00);
        check("rp_pend_b", rf.pending_b, 1'b0);
        check("rp_data_b", rf.data_out_b, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/register_file_2r1w.md
# register_file_2r1w

Parametrised register file: one write port, two independent read ports, a per-entry pending scoreboard, and write-to-read bypass. It is the next generation of the single-port 16x8 register unit. It serves as the operand store for the datapath. Two source operands can be read while a result is written in the same cycle, and an issue stage can mark destinations as not-yet-written.

## Interface
- DATA_WIDTH, 8, width of each entry and of data ports
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH entries
- ZERO_REG, 0, when 1 entry 0 is hardwired to zero, writes to it ignored, never pending
- clock  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high; one clock, reset synchronous active-high is fixed
- load  in  1  write enable
- waddr  in  ADDR_WIDTH  write address
- data_in  in  DATA_WIDTH  write data
- reserve  in  1  mark entry raddr pending
- reserve_addr  in  ADDR_WIDTH  entry to mark pending
- raddr_a, raddr_b  in  ADDR_WIDTH  read addresses
- data_out_a, data_out_b  out  DATA_WIDTH  registered read data
- pending_a, pending_b  out  1  registered pending flag of entry read
- any_pending  out  1  registered OR of all pending bits

## Operation
- Storage: DEPTH x DATA_WIDTH array plus DEPTH pending bits.
- Reset (clock edge with reset=1) has priority over everything:
  - all entries and pending bits go to 0;
  - data_out_a/b, pending_a/b and any_pending go to 0;
  - load and reserve in that cycle are ignored.
- Write: on an edge with load=1, entry[waddr] <= data_in and pending[waddr] <= 0.
- Reserve: on an edge with reserve=1, pending[reserve_addr] <= 1.
- Same edge, same address for load and reserve: data is written and pending ends at 1. The reserve wins because it is a new producer.
- Read (each port independently): on every edge, data_out_x <= entry[raddr_x] and pending_x <= pending[raddr_x].
- Bypass: if load=1 and waddr==raddr_x on the same edge, the port returns data_in and pending_x reflects the post-update pending value. It is 0 unless the same-edge reserve hits that address.
- Both ports reading the same address return identical values.
- ZERO_REG=1:
  - reads of address 0 return 0 with pending 0, bypass included;
  - load/reserve to address 0 have no effect.
- any_pending is registered from the post-update pending vector.

## Timing
- Read latency: 1 cycle. Address presented before edge N yields data after edge N.
- Write latency: 1 cycle. Data is visible to a non-bypassed read issued on the next edge. With bypass it is visible on the same edge.
- No stall or handshake; every port accepts every cycle.
- Reset mid-sequence discards any in-flight write or reserve on that edge. The first post-reset read returns 0 with pending 0.
- Widths are exact; no truncation or extension is performed on data.
- Addresses are always in range (DEPTH = 2**ADDR_WIDTH), so no wrap handling is needed.

## Test plan
- Reset then read: reset=1 for one edge, then raddr_a=1, raddr_b=15. Required: both data_out 0, pending_a/b 0, any_pending 0.
- Write/read: load waddr=1 data 8'h04, then waddr=2 data 8'h05. Then raddr_a=1, raddr_b=2. Required: data_out_a=8'h04, data_out_b=8'h05 after one edge.
- Bypass: same edge load waddr=3 data 8'hA5 and raddr_a=3, raddr_b=3. Required: both outputs 8'hA5 after that edge.
- Scoreboard:
  - reserve addr 7, then read raddr_a=7: required pending_a=1, any_pending=1;
  - load waddr=7 data 8'h3C, then read: required pending_a=0, data_out_a=8'h3C, any_pending=0;
  - same-edge reserve+load on 7: required pending 1.
- ZERO_REG=1 instance: load waddr=0 data 8'hFF and reserve addr 0, then read addr 0 on both ports. Required: data 0, pending 0, any_pending 0.
- Reset priority: write 8'h11 to addr 4, then assert reset together with load waddr=4 data 8'h22. Read addr 4 after reset. Required: data_out 0.
